// File: rtl/multicycle_control_if.sv
// Control-side bundle between the multicycle controller and its datapath:
// instruction fields and handshake in, mux selects and write strobes out.
interface multicycle_control_if;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       pc_write;
   logic       reg_write;
   logic       mem_write;
   logic       ir_write;
   logic       adr_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic [1:0] alu_control;
   logic [3:0] flags;
   logic [3:0] state;

   modport master (
      input  op, funct, rd, cond, alu_flags, mem_ready,
      output pc_write, reg_write, mem_write, ir_write, adr_src, alu_src_a,
             alu_src_b, result_src, imm_src, reg_src, alu_control, flags, state
   );

   modport slave (
      output op, funct, rd, cond, alu_flags, mem_ready,
      input  pc_write, reg_write, mem_write, ir_write, adr_src, alu_src_a,
             alu_src_b, result_src, imm_src, reg_src, alu_control, flags, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset main controller: phase sequencing FSM, NZCV flag
// register, condition evaluation and datapath select/strobe decode.
module multicycle_control (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;

   logic       pc_write_c, reg_write_c, mem_write_c, ir_write_c;
   logic [3:0] cmd;
   logic       rd_is_pc;
   logic       arith_cmd;
   logic       wr;

   assign cmd       = bus.funct[4:1];
   assign rd_is_pc  = (bus.rd == 4'd15);
   assign arith_cmd = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);

   function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      logic res;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: res = z;
         4'b0001: res = !z;
         4'b0010: res = cf;
         4'b0011: res = !cf;
         4'b0100: res = n;
         4'b0101: res = !n;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = !z && (n == v);
         4'b1101: res = z || (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   always_comb begin
      state_d         = S_FETCH;
      flags_d         = flags_q;
      cond_ex_d       = cond_ex_q;
      pc_write_c      = 1'b0;
      reg_write_c     = 1'b0;
      mem_write_c     = 1'b0;
      ir_write_c      = 1'b0;
      bus.adr_src     = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.result_src  = 2'b00;
      bus.imm_src     = 2'b00;
      bus.reg_src     = 2'b00;
      bus.alu_control = 2'b00;
      wr              = 1'b0;

      case (state_q)
         S_FETCH: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            ir_write_c     = bus.mem_ready;
            pc_write_c     = bus.mem_ready;
            state_d        = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            if (bus.op == 2'b01)      bus.reg_src = 2'b10;
            else if (bus.op == 2'b10) bus.reg_src = 2'b01;
            cond_ex_d = cond_check(bus.cond, flags_q);
            case (bus.op)
               2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            bus.alu_src_b = 2'b01;
            bus.imm_src   = 2'b01;
            state_d       = bus.funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.adr_src = 1'b1;
            state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            bus.result_src = 2'b01;
            reg_write_c    = cond_ex_q & ~rd_is_pc;
            pc_write_c     = cond_ex_q & rd_is_pc;
            state_d        = S_FETCH;
         end
         S_MEMWR: begin
            bus.adr_src = 1'b1;
            mem_write_c = cond_ex_q;
            // A squashed store never waits on the memory handshake.
            state_d     = (!cond_ex_q || bus.mem_ready) ? S_FETCH : S_MEMWR;
         end
         S_EXECR, S_EXECI: begin
            if (state_q == S_EXECI) begin
               bus.alu_src_b = 2'b01;
               bus.imm_src   = 2'b00;
            end
            case (cmd)
               4'b0100: bus.alu_control = 2'b00;
               4'b0010: bus.alu_control = 2'b01;
               4'b0000: bus.alu_control = 2'b10;
               4'b1100: bus.alu_control = 2'b11;
               4'b1010: bus.alu_control = 2'b01;
               default: bus.alu_control = 2'b00;
            endcase
            if (cond_ex_q && bus.funct[0]) begin
               flags_d[3:2] = bus.alu_flags[3:2];
               if (arith_cmd) flags_d[1:0] = bus.alu_flags[1:0];
            end
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            wr          = cond_ex_q & (cmd != 4'b1010);
            reg_write_c = wr & ~rd_is_pc;
            pc_write_c  = wr & rd_is_pc;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_b   = 2'b01;
            bus.imm_src     = 2'b10;
            bus.result_src  = 2'b10;
            pc_write_c      = cond_ex_q;
            state_d         = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are gated by rst_n so an asserted reset kills writes within the cycle.
   assign bus.pc_write  = pc_write_c  & rst_n;
   assign bus.reg_write = reg_write_c & rst_n;
   assign bus.mem_write = mem_write_c & rst_n;
   assign bus.ir_write  = ir_write_c  & rst_n;
   assign bus.flags     = flags_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks DP, LDR, STR, CMP, branch and
// undefined instructions through the FSM and checks selects, strobes and flags.
module tb_multicycle_control;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   multicycle_control_if bus_if();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                            input logic [3:0] rd, input logic [3:0] cond);
      bus_if.op    = op;
      bus_if.funct = funct;
      bus_if.rd    = rd;
      bus_if.cond  = cond;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      set_instr(2'b00, 6'b000000, 4'd0, 4'b1110);
      bus_if.alu_flags = 4'b0000;
      bus_if.mem_ready = 1'b1;

      // Reset held with mem_ready high
      tick(); tick();
      check("rst_state", 8'(bus_if.state), 8'd0);
      check("rst_flags", 8'(bus_if.flags), 8'h0);
      check("rst_strobes", {4'b0, bus_if.pc_write, bus_if.reg_write,
                            bus_if.mem_write, bus_if.ir_write}, 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ir_write", 8'(bus_if.ir_write), 8'd1);
      check("rel_pc_write", 8'(bus_if.pc_write), 8'd1);

      // ADDS r3 (register form)
      set_instr(2'b00, 6'b001001, 4'd3, 4'b1110);
      bus_if.alu_flags = 4'b0110;
      tick(); check("adds_decode", 8'(bus_if.state), 8'd1);
      tick(); check("adds_execr", 8'(bus_if.state), 8'd6);
      check("adds_aluctl", 8'(bus_if.alu_control), 8'd0);
      check("adds_srcb", 8'(bus_if.alu_src_b), 8'd0);
      tick(); check("adds_aluwb", 8'(bus_if.state), 8'd8);
      check("adds_flags", 8'(bus_if.flags), 8'h6);
      check("adds_regwr", 8'(bus_if.reg_write), 8'd1);
      check("adds_pcwr", 8'(bus_if.pc_write), 8'd0);
      tick(); check("adds_fetch", 8'(bus_if.state), 8'd0);

      // LDR pc with two stall cycles in MEMRD
      set_instr(2'b01, 6'b011001, 4'd15, 4'b1110);
      tick(); check("ldr_decode", 8'(bus_if.state), 8'd1);
      check("ldr_regsrc", 8'(bus_if.reg_src), 8'h2);
      tick(); check("ldr_memadr", 8'(bus_if.state), 8'd2);
      check("ldr_immsrc", 8'(bus_if.imm_src), 8'd1);
      tick(); check("ldr_memrd", 8'(bus_if.state), 8'd3);
      check("ldr_adrsrc", 8'(bus_if.adr_src), 8'd1);
      bus_if.mem_ready = 1'b0;
      tick(); check("ldr_stall1", 8'(bus_if.state), 8'd3);
      tick(); check("ldr_stall2", 8'(bus_if.state), 8'd3);
      bus_if.mem_ready = 1'b1;
      tick(); check("ldr_memwb", 8'(bus_if.state), 8'd4);
      check("ldr_pcwr", 8'(bus_if.pc_write), 8'd1);
      check("ldr_regwr", 8'(bus_if.reg_write), 8'd0);
      check("ldr_ressrc", 8'(bus_if.result_src), 8'd1);
      tick(); check("ldr_fetch", 8'(bus_if.state), 8'd0);

      // STRNE with Z=1: squashed, no wait in MEMWR
      set_instr(2'b01, 6'b011000, 4'd2, 4'b0001);
      tick(); tick();
      tick(); check("strne_memwr", 8'(bus_if.state), 8'd5);
      bus_if.mem_ready = 1'b0;
      #1;
      check("strne_memwrite", 8'(bus_if.mem_write), 8'd0);
      tick(); check("strne_exit", 8'(bus_if.state), 8'd0);
      check("fetch_stall_ir", 8'(bus_if.ir_write), 8'd0);
      tick(); check("fetch_stall_state", 8'(bus_if.state), 8'd0);
      bus_if.mem_ready = 1'b1;

      // CMP sets flags, no writeback
      set_instr(2'b00, 6'b010101, 4'd4, 4'b1110);
      bus_if.alu_flags = 4'b1000;
      tick(); tick();
      check("cmp_execr", 8'(bus_if.state), 8'd6);
      check("cmp_aluctl", 8'(bus_if.alu_control), 8'd1);
      tick(); check("cmp_flags", 8'(bus_if.flags), 8'h8);
      check("cmp_regwr", 8'(bus_if.reg_write), 8'd0);
      tick();

      // BEQ with Z=0: not taken
      set_instr(2'b10, 6'b000000, 4'd0, 4'b0000);
      tick(); check("beqn_regsrc", 8'(bus_if.reg_src), 8'h1);
      tick(); check("beqn_branch", 8'(bus_if.state), 8'd9);
      check("beqn_pcwr", 8'(bus_if.pc_write), 8'd0);
      tick();

      // ANDS immediate: N,Z update, C,V kept
      set_instr(2'b00, 6'b100001, 4'd5, 4'b1110);
      bus_if.alu_flags = 4'b0111;
      tick(); tick();
      check("ands_execi", 8'(bus_if.state), 8'd7);
      check("ands_aluctl", 8'(bus_if.alu_control), 8'h2);
      check("ands_srcb", 8'(bus_if.alu_src_b), 8'd1);
      tick(); check("ands_flags", 8'(bus_if.flags), 8'h4);
      tick();

      // BEQ with Z=1: taken
      set_instr(2'b10, 6'b000000, 4'd0, 4'b0000);
      tick(); tick();
      check("beqt_branch", 8'(bus_if.state), 8'd9);
      check("beqt_pcwr", 8'(bus_if.pc_write), 8'd1);
      check("beqt_immsrc", 8'(bus_if.imm_src), 8'h2);
      tick();

      // Undefined op returns straight to FETCH
      set_instr(2'b11, 6'b000000, 4'd0, 4'b1110);
      tick(); check("undef_decode", 8'(bus_if.state), 8'd1);
      check("undef_strobes", {4'b0, bus_if.pc_write, bus_if.reg_write,
                              bus_if.mem_write, bus_if.ir_write}, 8'h0);
      tick(); check("undef_fetch", 8'(bus_if.state), 8'd0);

      // STR stalled in MEMWR, then reset mid-access
      set_instr(2'b01, 6'b011000, 4'd2, 4'b1110);
      tick(); tick();
      bus_if.mem_ready = 1'b0;
      tick(); check("str_memwr", 8'(bus_if.state), 8'd5);
      check("str_memwrite", 8'(bus_if.mem_write), 8'd1);
      tick(); check("str_hold", 8'(bus_if.state), 8'd5);
      check("str_memwrite_hold", 8'(bus_if.mem_write), 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("str_rst_memwrite", 8'(bus_if.mem_write), 8'd0);
      check("str_rst_state", 8'(bus_if.state), 8'd0);
      check("str_rst_flags", 8'(bus_if.flags), 8'h0);
      tick();
      rst_n = 1'b1;
      bus_if.mem_ready = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main controller for the multicycle ARM-subset core. It sequences the shared datapath across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles so that one ALU, one memory port and the register file serve every instruction phase. It also holds the architectural NZCV flags, evaluates condition codes and drives every mux select and write strobe. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  2  instr[27:26]: 00 data-processing, 01 LDR/STR, 10 B, 11 undefined
- funct  in  6  instr[25:20]: [5] immediate operand, [4:1] cmd, [0] S (DP) or L (mem)
- rd  in  4  instr[15:12]
- cond  in  4  instr[31:28]
- alu_flags  in  4  {N,Z,C,V} from the ALU in the current cycle
- mem_ready  in  1  memory completes the access this cycle
- pc_write, reg_write, mem_write, ir_write  out  1  write strobes
- adr_src  out  1  0 = PC, 1 = ALUOut
- alu_src_a  out  1  0 = RD1, 1 = PC
- alu_src_b  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- imm_src  out  2  00 = 8-bit DP, 01 = 12-bit mem, 10 = 24-bit branch
- reg_src  out  2  [0]=1 selects R15 for RA1 (B); [1]=1 selects Rd for RA2 (STR)
- alu_control  out  2  00 add, 01 sub, 10 and, 11 orr
- flags  out  4  architectural {N,Z,C,V}
- state  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 return to FETCH.
- Default for any output not listed for a state: 0.
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, add, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, add, result_src=10. reg_src=2'b10 if op=01, 2'b01 if op=10. cond_ex_q <= condcheck(cond, flags). Next state: op 01 -> MEMADR; op 00 -> funct[5] ? EXECI : EXECR; op 10 -> BRANCH; op 11 -> FETCH with no side effects.
- MEMADR: alu_src_b=01, imm_src=01, add. Next state: funct[0] ? MEMRD : MEMWR.
- MEMRD: adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01. reg_write = cond_ex_q & (rd≠15); pc_write = cond_ex_q & (rd=15). Next state FETCH.
- MEMWR: adr_src=1; mem_write = cond_ex_q, held through the stall. Hold until mem_ready, then go to FETCH. If cond_ex_q=0, go to FETCH immediately without waiting.
- EXECR (alu_src_b=00) / EXECI (alu_src_b=01, imm_src=00): alu_control from cmd.
  - Mapping: 0100 -> 00 add, 0010 -> 01 sub, 0000 -> 10 and, 1100 -> 11 orr, 1010 CMP -> 01 sub; any other cmd -> 00.
  - Flag update at the exit edge, if cond_ex_q & funct[0]: N,Z <= alu_flags; C,V <= alu_flags only for add/sub/CMP, otherwise unchanged.
  - Next state ALUWB.
- ALUWB: result_src=00. wr = cond_ex_q & ~(cmd=1010). reg_write = wr & (rd≠15); pc_write = wr & (rd=15). Next state FETCH.
- BRANCH: alu_src_b=01, imm_src=10, add, result_src=10, pc_write=cond_ex_q. Next state FETCH.
- condcheck: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 1; all others 0.

## Timing
- Moore-style outputs decode from registered state. Exception: FETCH ir_write and pc_write also depend combinationally on mem_ready.
- Reset (async assert, sync-safe release): state=FETCH, flags=0000, cond_ex_q=0. While rst_n=0 all strobes are forced 0.
- Reset mid-MEMWR: mem_write drops immediately, with no further writes.
- Cycles per instruction with zero stall: DP 4, LDR 5, STR 4, B 3. Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds 1.
- Condition is sampled once in DECODE. A flag write in EXECR/EXECI never affects the same instruction's writeback.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 -> state=0, flags=0000, all strobes 0. Release -> ir_write=pc_write=1 in the first cycle.
- ADDS register form (op=00, funct=001001, cond=1110, rd=3, alu_flags=0110) -> states 0,1,6,8. alu_control=00 in EXECR; flags=0110 after EXECR; reg_write=1 in ALUWB.
- LDR with mem_ready low for 2 cycles in MEMRD (funct=011001, rd=15) -> states 0,1,2,3,3,3,4. pc_write=1 and reg_write=0 in MEMWB.
- STRNE with flags Z=1 (cond=0001) -> mem_write never asserts; MEMWR exits to FETCH in 1 cycle.
- CMP (cmd=1010, S=1, alu_flags=1000) -> alu_control=01; flags=1000 after execute; reg_write=0 in ALUWB.
- BEQ taken (Z=1) then not taken (Z=0) -> BRANCH pc_write=1, then 0. op=11 -> DECODE returns to FETCH with no strobes.
